// File: rtl/conv_weight_stream_tx_3x3_if.sv
// Bundle for the weight transmitter: control pulses, the weight-memory
// read port and the outgoing weight stream.
// master = the transmitter, slave = its environment (controller, memory, consumer).
interface conv_weight_stream_tx_3x3_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17
);
  logic                  start;
  logic                  next_group;
  logic                  hold;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  valid_weight_out;
  logic [DATA_WIDTH-1:0] weight_out;
  logic                  group_last;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] checksum_out;

  modport master (
    input  start, next_group, hold, mem_rd_data,
    output mem_rd_en, mem_addr, valid_weight_out, weight_out,
           group_last, busy, done, checksum_out
  );

  modport slave (
    output start, next_group, hold, mem_rd_data,
    input  mem_rd_en, mem_addr, valid_weight_out, weight_out,
           group_last, busy, done, checksum_out
  );
endinterface

// File: rtl/conv_weight_stream_tx_3x3.sv
// Weight transmitter for 3x3 conv layers: reads kernel weights from a
// 1-cycle-latency memory and streams them one output-channel group at a time.
// Optional macro WEIGHT_STREAM_CHECKSUM_EN adds a per-group wrapping checksum;
// without it checksum_out is tied to 0.
//
// state     | meaning
// IDLE      | waiting for start
// STREAM    | issuing reads for the current group (paused while hold is high)
// WAIT_NEXT | group fully issued, waiting for next_group
module conv_weight_stream_tx_3x3 #(
  parameter int DATA_WIDTH      = 32,
  parameter int CHANNEL_NUM_IN  = 64,
  parameter int CHANNEL_NUM_OUT = 128,
  parameter int KERNEL          = 3,
  parameter int ADDR_WIDTH      = 17
) (
  input  logic clk,
  input  logic reset,
  conv_weight_stream_tx_3x3_if.master bus
);
  localparam int G     = CHANNEL_NUM_IN * KERNEL * KERNEL;
  localparam int CNT_W = (G > 1) ? $clog2(G) : 1;
  localparam int OC_W  = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_NEXT} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] rd_ptr, last_addr;
  logic [CNT_W-1:0]      rd_cnt;
  logic [OC_W-1:0]       oc;
  logic                  busy_q;
  logic                  issue, grp_end, layer_end, start_ok;
  logic                  v1, gl1, dn1;
  logic                  valid_q, gl_q, done_q;
  logic [DATA_WIDTH-1:0] weight_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start_ok) state_nxt = STREAM;
      STREAM:    if (grp_end)  state_nxt = layer_end ? IDLE : WAIT_NEXT;
      WAIT_NEXT: if (bus.next_group) state_nxt = STREAM;
      default:   state_nxt = IDLE;
    endcase
  end

  // FSM decode: read issue, group/layer end, start acceptance (blocked while
  // busy or while earlier reads are still in the pipeline).
  always_comb begin
    issue     = (state == STREAM) && !bus.hold;
    grp_end   = issue && (rd_cnt == CNT_W'(G - 1));
    layer_end = grp_end && (oc == OC_W'(CHANNEL_NUM_OUT - 1));
    start_ok  = (state == IDLE) && bus.start && !busy_q && !v1 && !valid_q;
  end

  // Address, in-group count, group index and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      last_addr <= '0;
      rd_cnt    <= '0;
      oc        <= '0;
      busy_q    <= 1'b0;
    end else begin
      if (start_ok) begin
        rd_ptr <= '0;
        rd_cnt <= '0;
        oc     <= '0;
        busy_q <= 1'b1;
      end else if (done_q) begin
        busy_q <= 1'b0;
      end
      if (issue) begin
        rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
        last_addr <= rd_ptr;
        rd_cnt    <= grp_end ? '0 : rd_cnt + CNT_W'(1);
      end
      if ((state == WAIT_NEXT) && bus.next_group) oc <= oc + OC_W'(1);
    end
  end

  // Two-stage output pipeline aligning flags with the registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1       <= 1'b0;
      gl1      <= 1'b0;
      dn1      <= 1'b0;
      valid_q  <= 1'b0;
      gl_q     <= 1'b0;
      done_q   <= 1'b0;
      weight_q <= '0;
    end else begin
      v1      <= issue;
      gl1     <= grp_end;
      dn1     <= layer_end;
      valid_q <= v1;
      gl_q    <= gl1;
      done_q  <= dn1;
      if (v1) weight_q <= bus.mem_rd_data;
    end
  end

`ifdef WEIGHT_STREAM_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] acc, csum_q;

  // Per-group wrapping sum; published the cycle after group_last.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      csum_q <= '0;
    end else if (start_ok) begin
      acc <= '0;
    end else if (valid_q) begin
      if (gl_q) begin
        csum_q <= acc + weight_q;
        acc    <= '0;
      end else begin
        acc <= acc + weight_q;
      end
    end
  end

  assign bus.checksum_out = csum_q;
`else
  assign bus.checksum_out = '0;
`endif

  assign bus.mem_rd_en        = issue;
  assign bus.mem_addr         = issue ? rd_ptr : last_addr;
  assign bus.valid_weight_out = valid_q;
  assign bus.weight_out       = weight_q;
  assign bus.group_last       = gl_q;
  assign bus.done             = done_q;
  assign bus.busy             = busy_q;
endmodule

// File: tb/tb_conv_weight_stream_tx_3x3.sv
// Bench for conv_weight_stream_tx_3x3 with CHANNEL_NUM_IN=2, CHANNEL_NUM_OUT=2,
// KERNEL=3 (G=18) and a memory holding mem[a] = a+1.
module tb_conv_weight_stream_tx_3x3;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NW = 36;
`ifdef WEIGHT_STREAM_CHECKSUM_EN
  localparam logic [31:0] EXP_CS0 = 32'd171;
  localparam logic [31:0] EXP_CS1 = 32'd495;
`else
  localparam logic [31:0] EXP_CS0 = 32'd0;
  localparam logic [31:0] EXP_CS1 = 32'd0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        gl;
    logic        dn;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  conv_weight_stream_tx_3x3_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  conv_weight_stream_tx_3x3 #(
    .DATA_WIDTH(DW), .CHANNEL_NUM_IN(2), .CHANNEL_NUM_OUT(2),
    .KERNEL(3), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Weight memory model: 1-cycle read latency, mem[a] = a+1.
  initial bus.mem_rd_data = '0;
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= 32'(bus.mem_addr) + 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a valid word appears.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bus.valid_weight_out) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", bus.weight_out, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("word_data", bus.weight_out, e.data);
          chk("word_group_last", {31'd0, bus.group_last}, {31'd0, e.gl});
          chk("word_done", {31'd0, bus.done}, {31'd0, e.dn});
        end
      end else if (bus.group_last || bus.done) begin
        chk("stray_flag", {30'd0, bus.group_last, bus.done}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, bus.valid_weight_out}, 0);
    chk({tag, "_rd_en"}, {31'd0, bus.mem_rd_en}, 0);
    chk({tag, "_addr"}, 32'(bus.mem_addr), 0);
    chk({tag, "_weight"}, bus.weight_out, 0);
    chk({tag, "_glast"}, {31'd0, bus.group_last}, 0);
    chk({tag, "_done"}, {31'd0, bus.done}, 0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 0);
    chk({tag, "_csum"}, bus.checksum_out, 0);
  endtask

  task automatic run_layer(input bit ign, input bit hld, input bit rst10);
    exp_t e;
    int wc, gl_seen, first_v, hl, extra;
    bit after_gl, after_done, finished, hold_done;
    wc = 0; gl_seen = 0; first_v = -1; hl = 0; extra = 0;
    after_gl = 0; after_done = 0; finished = 0; hold_done = 0;
    for (int a = 0; a < NW; a++) begin
      e.data = 32'(a + 1);
      e.gl   = (a % 18) == 17;
      e.dn   = (a == NW - 1);
      sb.push_back(e);
    end
    bus.start = 1'b1;
    for (int step = 0; step < 400 && !finished; step++) begin
      tick();
      bus.start      = 1'b0;
      bus.next_group = 1'b0;
      if (step == 0) begin
        chk("rd_en_cycle1", {31'd0, bus.mem_rd_en}, 1);
        chk("busy_cycle1", {31'd0, bus.busy}, 1);
      end
      if (after_gl) begin
        chk("checksum_group0", bus.checksum_out, EXP_CS0);
        after_gl = 0;
      end
      if (after_done) begin
        chk("busy_after_done", {31'd0, bus.busy}, 0);
        chk("checksum_group1", bus.checksum_out, EXP_CS1);
        finished = 1;
      end else begin
        if (hl > 0) begin
          if (bus.valid_weight_out) extra++;
          hl--;
          if (hl == 0) begin
            bus.hold = 1'b0;
            chk("hold_extra_words_le2", {31'd0, extra <= 2}, 1);
          end
        end
        if (bus.valid_weight_out) begin
          wc++;
          if (first_v < 0) first_v = step;
        end
        if (hld && wc == 7 && !hold_done) begin
          bus.hold = 1'b1;
          hl = 5;
          extra = 0;
          hold_done = 1;
        end
        if (ign && step == 5) bus.next_group = 1'b1;
        if (ign && step == 8) bus.start = 1'b1;
        if (bus.group_last) begin
          gl_seen++;
          if (gl_seen == 1) begin
            bus.next_group = 1'b1;
            after_gl = 1;
          end
        end
        if (bus.done) after_done = 1;
        if (rst10 && wc == 10) begin
          reset = 1'b1;
          tick();
          sb.delete();
          chk_all_zero("mid_reset");
          reset = 1'b0;
          finished = 1;
        end
      end
    end
    if (!finished) chk("layer_timeout", 0, 1);
    if (rst10) begin
      for (int i = 0; i < 10; i++) begin
        tick();
        chk("no_valid_after_reset", {31'd0, bus.valid_weight_out}, 0);
      end
    end else begin
      chk("first_valid_latency", 32'(first_v), 2);
      chk("word_count", 32'(wc), NW);
      chk("group_last_count", 32'(gl_seen), 2);
      chk("scoreboard_drained", 32'(sb.size()), 0);
    end
    sb.delete();
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.next_group = 1'b0;
    bus.hold = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset_state");
    reset = 1'b0;
    repeat (2) tick();
    run_layer(0, 0, 0);
    run_layer(1, 0, 0);
    run_layer(0, 1, 0);
    run_layer(0, 0, 1);
    run_layer(0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/conv_weight_stream_tx_3x3.md
# conv_weight_stream_tx_3x3

Weight transmitter for the 3x3 convolution layers. It reads a layer's kernel weights from a single-port weight memory with 1-cycle read latency. It drives them as the `valid_weight_in` / `weight_in` stream that a conv layer top consumes, one output-channel group at a time. It pauses between groups until the consumer requests the next one, and it never runs ahead of the layer's weight buffer.

## Interface
- `DATA_WIDTH`, 32: weight word width.
- `CHANNEL_NUM_IN`, 64: input channels per kernel.
- `CHANNEL_NUM_OUT`, 128: output channels, which is also the number of groups.
- `KERNEL`, 3: kernel width; kernel size is `KERNEL*KERNEL`.
- `ADDR_WIDTH`, 17: memory address width; must satisfy `2^ADDR_WIDTH >= CHANNEL_NUM_OUT*CHANNEL_NUM_IN*KERNEL*KERNEL`.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: one-cycle pulse; begins a layer load at group 0.
- `next_group`, input, 1: pulse from the consumer requesting the next group.
- `hold`, input, 1: while high, no new memory reads are issued.
- `mem_rd_en`, output, 1: memory read strobe.
- `mem_addr`, output, `ADDR_WIDTH`: memory read address.
- `mem_rd_data`, input, `DATA_WIDTH`: read data, valid the cycle after `mem_rd_en`.
- `valid_weight_out`, output, 1: marks `weight_out` as valid.
- `weight_out`, output, `DATA_WIDTH`: weight word.
- `group_last`, output, 1: high with the last word of each group.
- `busy`, output, 1: high from the cycle after `start` is accepted until `done`.
- `done`, output, 1: one-cycle pulse with the final word of the layer.
- `checksum_out`, output, `DATA_WIDTH`: group checksum (see Configuration).

## Operation
- Group size `G = CHANNEL_NUM_IN*KERNEL*KERNEL`. Words are emitted in ascending address order: output channel, then input channel, then kernel row, then kernel column. Address = `oc*G + ic*KERNEL*KERNEL + k`.
- State machine states: IDLE, STREAM, WAIT_NEXT.
- IDLE, on `start`: load address 0 and group 0; go to STREAM. `busy` rises the next cycle.
- STREAM: each cycle with `hold` low, assert `mem_rd_en` and increment the address. After the G-th read of the group is issued:
  - if that group is the last (`oc == CHANNEL_NUM_OUT-1`), go to IDLE;
  - otherwise go to WAIT_NEXT.
- WAIT_NEXT, on `next_group`: go to STREAM. The address continues at `(oc+1)*G`.
- Output pipeline:
  - The read-issue flag is delayed 2 cycles to form `valid_weight_out`.
  - `weight_out` is registered from `mem_rd_data`.
  - `group_last` and `done` travel with the same 2-cycle pipeline as the flag.
- Reads already in flight when `hold` rises still complete; up to 2 words are emitted after `hold` rises.
- Ignored inputs:
  - `start` while `busy` is high or while reads are in flight.
  - `next_group` outside WAIT_NEXT.
- `next_group` and `hold` in the same cycle in WAIT_NEXT: the state goes to STREAM, but no read is issued that cycle.
- `busy` falls the cycle after `done`.

## Timing
- Reset values: every output is 0, and the state is IDLE.
- Reset mid-operation: all in-flight reads are discarded. No `valid_weight_out` is asserted in the cycle after reset.
- Latency:
  - `start` sampled at cycle 0 → first `mem_rd_en` at cycle 1 → first `valid_weight_out` at cycle 3.
  - `next_group` sampled at cycle n → first read at cycle n+1 → first valid word at cycle n+3.
- With `hold` low, a group is G consecutive valid cycles with no gaps.
- `mem_addr` holds its last value when `mem_rd_en` is low.
- The address counter never wraps within a layer. The last address issued is `CHANNEL_NUM_OUT*G-1`.

## Configuration
- Macro: `WEIGHT_STREAM_CHECKSUM_EN`.
- Defined:
  - A wrapping `DATA_WIDTH`-bit sum of every emitted `weight_out` is kept per group.
  - `checksum_out` is updated in the cycle after `group_last` and holds until the next group ends.
  - The accumulator clears at `start` and after each group.
- Undefined: the accumulator is absent and `checksum_out` is tied to 0.

## Test plan
Unless stated otherwise, scenarios use `CHANNEL_NUM_IN=2`, `CHANNEL_NUM_OUT=2`, `KERNEL=3` (G=18), and a memory where `mem[a] = a+1`.
- Basic layer:
  - Stimulus: `start`, then `next_group` after `group_last`.
  - Response: 36 words with values 1..36; `group_last` on words 18 and 36; `done` on word 36; first valid word 3 cycles after `start`.
- Hold mid-group:
  - Stimulus: `hold` high for 5 cycles starting at word 7.
  - Response: at most 2 more words emitted, then a gap; the sequence resumes gap-free with no word lost or duplicated; still 18 words in the group.
- Ignored pulses:
  - Stimulus: `next_group` during STREAM, and `start` while `busy` is high.
  - Response: both ignored; the sequence is identical to the basic layer.
- Reset mid-stream:
  - Stimulus: `reset` at word 10.
  - Response: all outputs 0 the next cycle; no valid words afterwards; a new `start` restarts at value 1.
- Checksum, with the macro defined:
  - Stimulus: the basic layer.
  - Response: `checksum_out` = 171 after group 0 and 495 after group 1.
- Checksum, with the macro undefined:
  - Stimulus: the basic layer.
  - Response: `checksum_out` stays 0.
